// File: rtl/kmeans_pkg.sv
// Shared types and constants for the k-means frame controller and its helpers.
package kmeans_pkg;

    localparam int MAX_PLAYERS = 4;
    localparam int X_W         = 11;
    localparam int Y_W         = 10;
    localparam int D_W         = 12;

    localparam logic [1:0] ONE_PLAYER    = 2'd0;
    localparam logic [1:0] TWO_PLAYERS   = 2'd1;
    localparam logic [1:0] THREE_PLAYERS = 2'd2;
    localparam logic [1:0] FOUR_PLAYERS  = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC     = 3'd1,
        ACCUM    = 3'd2,
        TABULATE = 3'd3,
        WAIT     = 3'd4,
        UPDATE   = 3'd5
    } state_e;

    // Saturating 3-bit increment used for the convergence counter.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? 3'd7 : (v + 3'd1);
    endfunction

endpackage

// File: rtl/kmeans_frame_controller_centroid_delta.sv
// centroid_delta: Manhattan distance |dx|+|dy| between a new and a previous centroid.
module centroid_delta
    import kmeans_pkg::*;
(
    input  logic [X_W-1:0] cur_x,
    input  logic [Y_W-1:0] cur_y,
    input  logic [X_W-1:0] prev_x,
    input  logic [Y_W-1:0] prev_y,
    output logic [D_W-1:0] delta
);

    logic [X_W-1:0] dx_s;
    logic [Y_W-1:0] dy_s;

    // Absolute per-axis differences, summed into a result wide enough for the worst case.
    always_comb begin
        if (cur_x >= prev_x) begin
            dx_s = cur_x - prev_x;
        end else begin
            dx_s = prev_x - cur_x;
        end
        if (cur_y >= prev_y) begin
            dy_s = cur_y - prev_y;
        end else begin
            dy_s = prev_y - cur_y;
        end
        delta = D_W'(dx_s) + D_W'(dy_s);
    end

endmodule

// File: rtl/kmeans_frame_controller.sv
// kmeans_frame_controller: sequences an external k-means engine frame by frame,
// captures its centroids and tracks how long the active centroids stay still.
module kmeans_frame_controller
    import kmeans_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CONV_THRESH    = 4,
    parameter int CONV_FRAMES    = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            frame_end_in,
    input  logic [1:0]                      num_players_in,
    input  logic                            km_valid_in,
    input  logic [MAX_PLAYERS-1:0][X_W-1:0] km_x_in,
    input  logic [MAX_PLAYERS-1:0][Y_W-1:0] km_y_in,
    output logic                            pixel_enable_out,
    output logic                            tabulate_out,
    output logic [1:0]                      num_players_out,
    output logic [MAX_PLAYERS-1:0][X_W-1:0] centroid_x_out,
    output logic [MAX_PLAYERS-1:0][Y_W-1:0] centroid_y_out,
    output logic                            centroids_valid_out,
    output logic                            converged_out,
    output logic                            timeout_out
);

    localparam int                WCNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [D_W-1:0]    THRESH    = D_W'(CONV_THRESH);
    // Frame counts above 7 can never be reached by the saturating counter.
    localparam logic [3:0]        FRAMES_W  = (CONV_FRAMES > 7) ? 4'd8 : 4'(CONV_FRAMES);

    state_e                          state_r;
    logic                            pix_en_r;
    logic                            tab_r;
    logic [1:0]                      np_r;
    logic [MAX_PLAYERS-1:0][X_W-1:0] cx_r;
    logic [MAX_PLAYERS-1:0][Y_W-1:0] cy_r;
    logic                            cvalid_r;
    logic                            conv_r;
    logic                            tmo_r;
    logic [WCNT_W-1:0]               wait_cnt_r;
    logic [2:0]                      conv_cnt_r;
    logic [MAX_PLAYERS-1:0][X_W-1:0] cap_x_r;
    logic [MAX_PLAYERS-1:0][Y_W-1:0] cap_y_r;
    logic                            pending_r;

    logic [MAX_PLAYERS-1:0][D_W-1:0] delta_s;
    logic [MAX_PLAYERS-1:0]          active_s;
    logic                            still_s;
    logic [2:0]                      conv_next_s;

    for (genvar g = 0; g < MAX_PLAYERS; g++) begin : g_delta
        centroid_delta u_delta (
            .cur_x  (cap_x_r[g]),
            .cur_y  (cap_y_r[g]),
            .prev_x (cx_r[g]),
            .prev_y (cy_r[g]),
            .delta  (delta_s[g])
        );
    end

    // Centroid indices 0..num_players_out take part in the convergence decision.
    always_comb begin
        active_s = {MAX_PLAYERS{1'b0}};
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            active_s[i] = (2'(i) <= np_r);
        end
    end

    // Stillness of all active centroids and the resulting next convergence count.
    always_comb begin
        still_s = 1'b1;
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            still_s = still_s & (~active_s[i] | (delta_s[i] <= THRESH));
        end
        if (still_s) begin
            conv_next_s = sat_inc3(conv_cnt_r);
        end else begin
            conv_next_s = 3'd0;
        end
    end

    // Frame sequencing FSM with all registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r    <= IDLE;
            pix_en_r   <= 1'b0;
            tab_r      <= 1'b0;
            np_r       <= ONE_PLAYER;
            cx_r       <= {(MAX_PLAYERS*X_W){1'b0}};
            cy_r       <= {(MAX_PLAYERS*Y_W){1'b0}};
            cvalid_r   <= 1'b0;
            conv_r     <= 1'b0;
            tmo_r      <= 1'b0;
            wait_cnt_r <= {WCNT_W{1'b0}};
            conv_cnt_r <= 3'd0;
            cap_x_r    <= {(MAX_PLAYERS*X_W){1'b0}};
            cap_y_r    <= {(MAX_PLAYERS*Y_W){1'b0}};
            pending_r  <= 1'b0;
        end else begin
            tab_r    <= 1'b0;
            cvalid_r <= 1'b0;
            tmo_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= SYNC;
                end
                SYNC: begin
                    if (frame_end_in) begin
                        state_r  <= ACCUM;
                        pix_en_r <= 1'b1;
                        np_r     <= num_players_in;
                        if (num_players_in != np_r) begin
                            conv_cnt_r <= 3'd0;
                            conv_r     <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (frame_end_in) begin
                        state_r  <= TABULATE;
                        pix_en_r <= 1'b0;
                        tab_r    <= 1'b1;
                    end
                end
                TABULATE: begin
                    state_r    <= WAIT;
                    wait_cnt_r <= {WCNT_W{1'b0}};
                    pending_r  <= 1'b0;
                end
                WAIT: begin
                    if (frame_end_in) begin
                        pending_r <= 1'b1;
                    end
                    if (km_valid_in) begin
                        cap_x_r <= km_x_in;
                        cap_y_r <= km_y_in;
                        state_r <= UPDATE;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        // Abandon this frame; outputs and convergence history are kept.
                        tmo_r     <= 1'b1;
                        pending_r <= 1'b0;
                        state_r   <= SYNC;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WCNT_W'(1);
                    end
                end
                UPDATE: begin
                    cx_r       <= cap_x_r;
                    cy_r       <= cap_y_r;
                    cvalid_r   <= 1'b1;
                    conv_cnt_r <= conv_next_s;
                    conv_r     <= ({1'b0, conv_next_s} >= FRAMES_W);
                    if (pending_r) begin
                        // A frame boundary already passed during WAIT: resume accumulating.
                        pending_r <= 1'b0;
                        state_r   <= ACCUM;
                        pix_en_r  <= 1'b1;
                        np_r      <= num_players_in;
                        if (num_players_in != np_r) begin
                            conv_cnt_r <= 3'd0;
                            conv_r     <= 1'b0;
                        end
                    end else begin
                        state_r <= SYNC;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign pixel_enable_out    = pix_en_r;
    assign tabulate_out        = tab_r;
    assign num_players_out     = np_r;
    assign centroid_x_out      = cx_r;
    assign centroid_y_out      = cy_r;
    assign centroids_valid_out = cvalid_r;
    assign converged_out       = conv_r;
    assign timeout_out         = tmo_r;

endmodule

// File: tb/tb_kmeans_frame_controller.sv
// Directed and randomized checks of kmeans_frame_controller against a frame-level model.
module tb_kmeans_frame_controller;
    import kmeans_pkg::*;

    localparam int TB_TIMEOUT = 64;
    localparam int TB_THRESH  = 4;
    localparam int TB_FRAMES  = 2;

    logic                            clk_in = 1'b0;
    logic                            rst_in = 1'b1;
    logic                            frame_end_in = 1'b0;
    logic [1:0]                      num_players_in = 2'd0;
    logic                            km_valid_in = 1'b0;
    logic [MAX_PLAYERS-1:0][X_W-1:0] km_x_in = '0;
    logic [MAX_PLAYERS-1:0][Y_W-1:0] km_y_in = '0;
    logic                            pixel_enable_out;
    logic                            tabulate_out;
    logic [1:0]                      num_players_out;
    logic [MAX_PLAYERS-1:0][X_W-1:0] centroid_x_out;
    logic [MAX_PLAYERS-1:0][Y_W-1:0] centroid_y_out;
    logic                            centroids_valid_out;
    logic                            converged_out;
    logic                            timeout_out;

    kmeans_frame_controller #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .CONV_THRESH    (TB_THRESH),
        .CONV_FRAMES    (TB_FRAMES)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .frame_end_in        (frame_end_in),
        .num_players_in      (num_players_in),
        .km_valid_in         (km_valid_in),
        .km_x_in             (km_x_in),
        .km_y_in             (km_y_in),
        .pixel_enable_out    (pixel_enable_out),
        .tabulate_out        (tabulate_out),
        .num_players_out     (num_players_out),
        .centroid_x_out      (centroid_x_out),
        .centroid_y_out      (centroid_y_out),
        .centroids_valid_out (centroids_valid_out),
        .converged_out       (converged_out),
        .timeout_out         (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level reference model
    int m_cx [MAX_PLAYERS];
    int m_cy [MAX_PLAYERS];
    int m_cnt;
    int m_np;
    int nx [MAX_PLAYERS];
    int ny [MAX_PLAYERS];
    bit in_accum;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            m_cx[i] = 0;
            m_cy[i] = 0;
        end
        m_cnt = 0;
        m_np  = 0;
    endfunction

    function automatic void model_update();
        bit still;
        still = 1'b1;
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            if (i <= m_np && (iabs(nx[i] - m_cx[i]) + iabs(ny[i] - m_cy[i])) > TB_THRESH) still = 1'b0;
            m_cx[i] = nx[i];
            m_cy[i] = ny[i];
        end
        m_cnt = still ? ((m_cnt < 7) ? m_cnt + 1 : 7) : 0;
    endfunction

    function automatic void model_enter_accum(input int np);
        if (np != m_np) m_cnt = 0;
        m_np = np;
    endfunction

    function automatic void rand_centroids(input bit jitter);
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            if (jitter) begin
                nx[i] = m_cx[i] + int'($urandom_range(6)) - 3;
                ny[i] = m_cy[i] + int'($urandom_range(6)) - 3;
                if (nx[i] < 0) nx[i] = 0;
                if (nx[i] > 2047) nx[i] = 2047;
                if (ny[i] < 0) ny[i] = 0;
                if (ny[i] > 1023) ny[i] = 1023;
            end else begin
                nx[i] = int'($urandom_range(2047));
                ny[i] = int'($urandom_range(1023));
            end
        end
    endfunction

    task automatic check_model(input string tag);
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            check($sformatf("%s_x%0d", tag, i), 32'(centroid_x_out[i]), m_cx[i]);
            check($sformatf("%s_y%0d", tag, i), 32'(centroid_y_out[i]), m_cy[i]);
        end
        check({tag, "_conv"}, 32'(converged_out), (m_cnt >= TB_FRAMES) ? 1 : 0);
        check({tag, "_np"}, 32'(num_players_out), m_np);
    endtask

    // Frame boundary seen in SYNC: accumulation must start on the next cycle.
    task automatic start_accum();
        frame_end_in = 1'b1;
        step();
        frame_end_in = 1'b0;
        model_enter_accum(int'(num_players_in));
        check("accum_entry_pe", 32'(pixel_enable_out), 1);
        check("accum_entry_np", 32'(num_players_out), m_np);
        check("accum_entry_conv", 32'(converged_out), (m_cnt >= TB_FRAMES) ? 1 : 0);
        in_accum = 1'b1;
    endtask

    // Accumulate for len cycles (last one carries frame_end), then pass TABULATE into WAIT.
    task automatic accum_to_wait(input int len, input bit stray_km, input bit fe_in_tab);
        int hi;
        int cv;
        hi = 0;
        cv = 0;
        for (int i = 0; i < len - 1; i++) begin
            hi += int'(pixel_enable_out);
            cv += int'(centroids_valid_out);
            if (stray_km && i == 1) begin
                km_valid_in = 1'b1;
                for (int j = 0; j < MAX_PLAYERS; j++) km_x_in[j] = 11'($urandom);
            end
            step();
            km_valid_in = 1'b0;
        end
        hi += int'(pixel_enable_out);
        frame_end_in = 1'b1;
        step();
        frame_end_in = 1'b0;
        check("accum_pe_cycles", hi, len);
        check("accum_no_cvalid", cv, 0);
        check("tab_pulse", 32'(tabulate_out), 1);
        check("tab_pe_low", 32'(pixel_enable_out), 0);
        frame_end_in = fe_in_tab;
        step();
        frame_end_in = 1'b0;
        check("tab_single", 32'(tabulate_out), 0);
        in_accum = 1'b0;
    endtask

    // From WAIT entry, return nx/ny after delay cycles, optionally with a coincident frame_end.
    task automatic deliver(input int delay, input bit fe);
        int tmo;
        int pe;
        tmo = 0;
        pe  = 0;
        for (int i = 0; i < delay; i++) begin
            tmo += int'(timeout_out);
            pe  += int'(pixel_enable_out);
            step();
        end
        tmo += int'(timeout_out);
        pe  += int'(pixel_enable_out);
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            km_x_in[i] = 11'(nx[i]);
            km_y_in[i] = 10'(ny[i]);
        end
        km_valid_in  = 1'b1;
        frame_end_in = fe;
        step();
        km_valid_in  = 1'b0;
        frame_end_in = 1'b0;
        check("wait_no_timeout", tmo, 0);
        check("wait_pe_low", pe, 0);
        check("update_cycle_cvalid", 32'(centroids_valid_out), 0);
        step();
        model_update();
        if (fe) model_enter_accum(int'(num_players_in));
        check("cvalid_pulse", 32'(centroids_valid_out), 1);
        check_model("upd");
        check("post_update_pe", 32'(pixel_enable_out), 32'(fe));
        step();
        check("cvalid_single", 32'(centroids_valid_out), 0);
        in_accum = fe;
    endtask

    // From WAIT entry with no results: the wait must be abandoned after TB_TIMEOUT cycles.
    task automatic wait_timeout();
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 4 * TB_TIMEOUT) begin
            step();
            n++;
            if (timeout_out === 1'b1) seen = 1'b1;
        end
        check("timeout_latency", n, TB_TIMEOUT);
        check("timeout_pe_low", 32'(pixel_enable_out), 0);
        check("timeout_no_cvalid", 32'(centroids_valid_out), 0);
        check_model("tmo");
        step();
        check("timeout_single", 32'(timeout_out), 0);
        in_accum = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        int acc;
        acc = 0;
        for (int i = 0; i < MAX_PLAYERS; i++) acc += int'(centroid_x_out[i]) + int'(centroid_y_out[i]);
        check({tag, "_centroids"}, acc, 0);
        check({tag, "_pe"}, 32'(pixel_enable_out), 0);
        check({tag, "_tab"}, 32'(tabulate_out), 0);
        check({tag, "_np"}, 32'(num_players_out), 0);
        check({tag, "_cvalid"}, 32'(centroids_valid_out), 0);
        check({tag, "_conv"}, 32'(converged_out), 0);
        check({tag, "_tmo"}, 32'(timeout_out), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe;
        int cv;
        model_reset();
        in_accum = 1'b0;

        // Reset state
        rst_in = 1'b1;
        step();
        step();
        check_zero("reset");
        rst_in = 1'b0;

        // Nine idle cycles before the first frame boundary: no accumulation yet
        pe = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            pe += int'(pixel_enable_out);
        end
        check("pre_frame_pe", pe, 0);

        // Long frame: enable high for 990 cycles, tabulate right after the closing pulse
        start_accum();
        accum_to_wait(990, 1'b0, 1'b0);

        // First update 50 cycles into WAIT, compared against zero centroids
        rand_centroids(1'b0);
        nx[0] = 320;
        ny[0] = 240;
        deliver(50, 1'b0);
        check("first_x0", 32'(centroid_x_out[0]), 320);
        check("first_y0", 32'(centroid_y_out[0]), 240);
        check("first_conv", 32'(converged_out), 0);

        // Two small moves of the only active centroid reach convergence
        start_accum();
        accum_to_wait(8, 1'b0, 1'b0);
        rand_centroids(1'b0);
        nx[0] = 322;
        ny[0] = 241;
        deliver(5, 1'b0);
        check("second_conv", 32'(converged_out), 0);
        start_accum();
        accum_to_wait(8, 1'b0, 1'b0);
        rand_centroids(1'b0);
        nx[0] = 321;
        ny[0] = 240;
        deliver(7, 1'b0);
        check("third_conv", 32'(converged_out), 1);

        // Player count change clears convergence on accumulation entry
        num_players_in = 2'd1;
        start_accum();
        check("np_change_conv", 32'(converged_out), 0);

        // Timeout, with a frame_end in TABULATE that must be ignored
        accum_to_wait(6, 1'b0, 1'b1);
        wait_timeout();
        start_accum();

        // Stray result during ACCUM; then result coincident with frame_end goes straight to ACCUM
        accum_to_wait(6, 1'b1, 1'b0);
        rand_centroids(1'b1);
        deliver(10, 1'b1);

        // frame_end in TABULATE ignored: a plain update returns to SYNC
        accum_to_wait(6, 1'b0, 1'b1);
        rand_centroids(1'b1);
        deliver(3, 1'b0);

        // Results outside WAIT are ignored
        km_valid_in = 1'b1;
        for (int j = 0; j < MAX_PLAYERS; j++) km_x_in[j] = 11'($urandom);
        step();
        km_valid_in = 1'b0;
        cv = 0;
        for (int i = 0; i < 4; i++) begin
            cv += int'(centroids_valid_out);
            step();
        end
        check("stray_sync_cvalid", cv, 0);
        check_model("stray_sync");

        // Randomized frames
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(3) == 0) num_players_in = 2'($urandom_range(3));
            if (!in_accum) start_accum();
            accum_to_wait(int'($urandom_range(12, 3)), 1'($urandom_range(1)), 1'b0);
            if ($urandom_range(7) == 0) begin
                wait_timeout();
            end else begin
                rand_centroids($urandom_range(3) != 0);
                deliver(int'($urandom_range(40)), 1'($urandom_range(1)));
            end
        end

        // Reset in the middle of ACCUM aborts everything
        if (!in_accum) start_accum();
        step();
        step();
        rst_in = 1'b1;
        step();
        check_zero("midreset");
        rst_in = 1'b0;
        model_reset();
        in_accum = 1'b0;
        for (int j = 0; j < MAX_PLAYERS; j++) km_x_in[j] = 11'($urandom_range(2047, 1));
        km_valid_in = 1'b1;
        step();
        km_valid_in = 1'b0;
        cv = 0;
        pe = 0;
        for (int i = 0; i < 6; i++) begin
            cv += int'(centroids_valid_out) + int'(tabulate_out);
            pe += int'(pixel_enable_out);
            step();
        end
        check("postreset_no_pulses", cv, 0);
        check("postreset_pe", pe, 0);
        check_model("postreset");

        // Normal operation resumes after the reset, comparing against zero centroids
        num_players_in = 2'd0;
        start_accum();
        accum_to_wait(5, 1'b0, 1'b0);
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            nx[i] = 0;
            ny[i] = 0;
        end
        nx[0] = 1;
        ny[0] = 2;
        deliver(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
